// File: rtl/frame_shadow_scanner.sv
// Shadow copy of the plotted frame plus a rectangular region scanner that
// counts pixels of a target color for collision decisions.
module frame_shadow_scanner #(
   parameter int unsigned MAX_X   = 320,
   parameter int unsigned MAX_Y   = 240,
   parameter int unsigned WIDTH_X = 9,
   parameter int unsigned WIDTH_Y = 9,
   parameter int unsigned BOX_W   = 6,
   parameter int unsigned CNT_W   = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               plot,
   input  logic [WIDTH_X-1:0] x,
   input  logic [WIDTH_Y-1:0] y,
   input  logic [2:0]         color,
   input  logic               scan_start,
   input  logic [WIDTH_X-1:0] scan_x,
   input  logic [WIDTH_Y-1:0] scan_y,
   input  logic [BOX_W-1:0]   scan_w,
   input  logic [BOX_W-1:0]   scan_h,
   input  logic [2:0]         match_color,
   output logic               scan_busy,
   output logic               scan_done,
   output logic [CNT_W-1:0]   match_count,
   output logic               hit
);

   localparam int unsigned DEPTH  = MAX_X * MAX_Y;
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam logic [WIDTH_X:0]    LIM_X  = (WIDTH_X+1)'(MAX_X);
   localparam logic [WIDTH_Y:0]    LIM_Y  = (WIDTH_Y+1)'(MAX_Y);
   localparam logic [ADDR_W-1:0]   STRIDE = ADDR_W'(MAX_X);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, next_state;

   logic [2:0]        mem [DEPTH];
   logic [2:0]        rdata;
   logic              wr_en_c;
   logic [ADDR_W-1:0] wr_addr_c;
   logic [ADDR_W-1:0] rd_addr_c;

   logic [WIDTH_X-1:0] sx_q;
   logic [WIDTH_Y-1:0] sy_q;
   logic [BOX_W-1:0]   w_q;
   logic [BOX_W-1:0]   h_q;
   logic [2:0]         mc_q;
   logic [BOX_W-1:0]   cx;
   logic [BOX_W-1:0]   cy;
   logic [CNT_W-1:0]   acc;
   logic               pend_q;
   logic               vld_q;

   logic [WIDTH_X:0]   px_c;
   logic [WIDTH_Y:0]   py_c;
   logic               in_range_c;
   logic               issue_c;
   logic               last_c;
   logic               start_c;
   logic               empty_c;
   logic               match_c;
   logic [CNT_W-1:0]   total_c;

   // Snoop path: a pixel outside the frame is dropped rather than wrapped into the next row.
   assign wr_en_c   = plot && ({1'b0, x} < LIM_X) && ({1'b0, y} < LIM_Y);
   assign wr_addr_c = ADDR_W'(y) * STRIDE + ADDR_W'(x);

   // Read-before-write: a same-cycle read of the written address returns the old color.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wr_addr_c] <= color;
      end
      rdata <= mem[rd_addr_c];
   end

   // Scan address generation with one extra bit so the sums cannot wrap.
   assign px_c       = {1'b0, sx_q} + (WIDTH_X+1)'(cx);
   assign py_c       = {1'b0, sy_q} + (WIDTH_Y+1)'(cy);
   assign in_range_c = (px_c < LIM_X) && (py_c < LIM_Y);
   assign rd_addr_c  = in_range_c ? (ADDR_W'(py_c) * STRIDE + ADDR_W'(px_c)) : '0;

   assign issue_c = (state == SCAN);
   assign last_c  = (cx == w_q - BOX_W'(1)) && (cy == h_q - BOX_W'(1));
   assign start_c = (state == IDLE) && scan_start;
   assign empty_c = (scan_w == '0) || (scan_h == '0);
   assign match_c = pend_q && vld_q && (rdata == mc_q);
   assign total_c = acc + CNT_W'(match_c);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (scan_start) next_state = empty_c ? DONE : SCAN;
         SCAN:    if (last_c) next_state = DRAIN;
         DRAIN:   next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Scan datapath: latched request, row-major counters, compare pipeline and results.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_busy   <= 1'b0;
         scan_done   <= 1'b0;
         match_count <= '0;
         hit         <= 1'b0;
         acc         <= '0;
         pend_q      <= 1'b0;
         vld_q       <= 1'b0;
         cx          <= '0;
         cy          <= '0;
         sx_q        <= '0;
         sy_q        <= '0;
         w_q         <= '0;
         h_q         <= '0;
         mc_q        <= '0;
      end else begin
         scan_busy <= (next_state == SCAN) || (next_state == DRAIN);
         scan_done <= (next_state == DONE);
         pend_q    <= issue_c;
         vld_q     <= issue_c && in_range_c;
         if (start_c) begin
            sx_q        <= scan_x;
            sy_q        <= scan_y;
            w_q         <= scan_w;
            h_q         <= scan_h;
            mc_q        <= match_color;
            cx          <= '0;
            cy          <= '0;
            acc         <= '0;
            match_count <= '0;
            hit         <= 1'b0;
         end else begin
            acc <= total_c;
            if (issue_c) begin
               if (cx == w_q - BOX_W'(1)) begin
                  cx <= '0;
                  cy <= cy + BOX_W'(1);
               end else begin
                  cx <= cx + BOX_W'(1);
               end
            end
            if (state == DRAIN) begin
               match_count <= total_c;
               hit         <= (total_c != '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_shadow_scanner.sv
// Scoreboard bench for frame_shadow_scanner: a frame model predicts each scan result.
module tb_frame_shadow_scanner;

   localparam int MX = 320;
   localparam int MY = 240;

   logic        clk = 1'b0;
   logic        reset;
   logic        plot;
   logic [8:0]  x;
   logic [8:0]  y;
   logic [2:0]  color;
   logic        scan_start;
   logic [8:0]  scan_x;
   logic [8:0]  scan_y;
   logic [5:0]  scan_w;
   logic [5:0]  scan_h;
   logic [2:0]  match_color;
   logic        scan_busy;
   logic        scan_done;
   logic [11:0] match_count;
   logic        hit;

   int total = 0;
   int bad   = 0;
   logic [2:0] model [int];
   int exp_q [$];

   frame_shadow_scanner dut (
      .clk         (clk),
      .reset       (reset),
      .plot        (plot),
      .x           (x),
      .y           (y),
      .color       (color),
      .scan_start  (scan_start),
      .scan_x      (scan_x),
      .scan_y      (scan_y),
      .scan_w      (scan_w),
      .scan_h      (scan_h),
      .match_color (match_color),
      .scan_busy   (scan_busy),
      .scan_done   (scan_done),
      .match_count (match_count),
      .hit         (hit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int model_count(input int sx, input int sy, input int w, input int h,
                                      input logic [2:0] mc);
      int n = 0;
      for (int cy = 0; cy < h; cy++) begin
         for (int cx = 0; cx < w; cx++) begin
            int px = sx + cx;
            int py = sy + cy;
            if (px < MX && py < MY && model.exists(py * MX + px) && model[py * MX + px] == mc)
               n++;
         end
      end
      return n;
   endfunction

   // Result checker: every done pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      int e;
      if (!reset && scan_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("count", 32'(match_count), 32'(e));
            check("hit", 32'(hit), 32'(e != 0));
            check("busy_at_done", 32'(scan_busy), 32'd0);
         end
      end
   end

   task automatic plot_px(input int px, input int py, input logic [2:0] c);
      @(negedge clk);
      plot  = 1'b1;
      x     = px[8:0];
      y     = py[8:0];
      color = c;
      @(posedge clk);
      #1 plot = 1'b0;
      if (px < MX && py < MY) model[py * MX + px] = c;
   endtask

   task automatic drive_scan(input int sx, input int sy, input int w, input int h,
                             input logic [2:0] mc);
      @(negedge clk);
      scan_x      = sx[8:0];
      scan_y      = sy[8:0];
      scan_w      = w[5:0];
      scan_h      = h[5:0];
      match_color = mc;
      scan_start  = 1'b1;
      @(posedge clk);
      #1 scan_start = 1'b0;
   endtask

   // Counts cycles after the start-sampling edge; cycle 1 is the one right after it.
   task automatic wait_done(input int lat_exp, input int k_init);
      int k = k_init;
      forever begin
         @(negedge clk);
         k++;
         if (scan_done) break;
         if (k > 5000) begin
            check("done_timeout", 32'(k), 32'(lat_exp));
            return;
         end
      end
      check("latency", 32'(k), 32'(lat_exp));
      @(negedge clk);
      check("done_width", 32'(scan_done), 32'd0);
   endtask

   task automatic do_scan(input int sx, input int sy, input int w, input int h,
                          input logic [2:0] mc);
      exp_q.push_back(model_count(sx, sy, w, h, mc));
      drive_scan(sx, sy, w, h, mc);
      wait_done((w == 0 || h == 0) ? 1 : w * h + 2, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; plot = 1'b0; x = '0; y = '0; color = '0;
      scan_start = 1'b0; scan_x = '0; scan_y = '0; scan_w = '0; scan_h = '0;
      match_color = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(scan_busy), 32'd0);
      check("rst_done", 32'(scan_done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_count", 32'(match_count), 32'd0);
      check("rst_hit", 32'(hit), 32'd0);

      // Define every pixel the scans touch so no result depends on uninitialised RAM.
      for (int yy = 0; yy <= 30; yy++)
         for (int xx = 0; xx <= 40; xx++) plot_px(xx, yy, 3'd0);
      for (int yy = 0; yy <= 10; yy++)
         for (int xx = 300; xx < MX; xx++) plot_px(xx, yy, 3'd0);

      // 4x3 block, exact and padded windows
      for (int yy = 20; yy < 23; yy++)
         for (int xx = 10; xx < 14; xx++) plot_px(xx, yy, 3'b010);
      do_scan(10, 20, 4, 3, 3'b010);
      do_scan(8, 19, 8, 5, 3'b010);
      do_scan(8, 19, 8, 5, 3'b111);

      // Right-edge clipping
      for (int yy = 0; yy < 5; yy++) begin
         plot_px(318, yy, 3'b001);
         plot_px(319, yy, 3'b001);
      end
      do_scan(316, 0, 6, 5, 3'b001);

      // Out-of-range plots must not alias
      plot_px(0, 6, 3'd0);
      plot_px(MX, 5, 3'd7);
      plot_px(5, MY, 3'd7);
      do_scan(0, 6, 1, 1, 3'd7);
      do_scan(0, 0, 1, 1, 3'd0);

      // Empty regions
      do_scan(10, 20, 0, 3, 3'b010);
      do_scan(10, 20, 4, 0, 3'b010);

      // Start and input changes while busy are ignored
      exp_q.push_back(model_count(10, 20, 4, 3, 3'b010));
      drive_scan(10, 20, 4, 3, 3'b010);
      @(negedge clk);
      scan_x = 9'd0; scan_y = 9'd0; scan_w = 6'd1; scan_h = 6'd1; match_color = 3'd0;
      scan_start = 1'b1;
      check("busy_mid", 32'(scan_busy), 32'd1);
      repeat (3) @(negedge clk);
      scan_start = 1'b0;
      wait_done(14, 4);
      repeat (30) @(negedge clk);

      // Reset mid-scan aborts without a done pulse; snoop writes continue in reset
      drive_scan(10, 20, 4, 3, 3'b010);
      repeat (5) @(negedge clk);
      reset = 1'b1; plot = 1'b1; x = 9'd60; y = 9'd60; color = 3'd4;
      @(posedge clk);
      #1 plot = 1'b0;
      model[60 * MX + 60] = 3'd4;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 32'(scan_busy), 32'd0);
      check("abort_count", 32'(match_count), 32'd0);
      check("abort_hit", 32'(hit), 32'd0);
      check("abort_done", 32'(scan_done), 32'd0);
      repeat (30) @(negedge clk);
      do_scan(60, 60, 1, 1, 3'd4);

      // Read and write of the same address in one cycle sees the old color
      plot_px(50, 50, 3'd5);
      exp_q.push_back(model_count(50, 50, 1, 1, 3'd5));
      drive_scan(50, 50, 1, 1, 3'd5);
      @(negedge clk);
      plot = 1'b1; x = 9'd50; y = 9'd50; color = 3'd6;
      @(posedge clk);
      #1 plot = 1'b0;
      model[50 * MX + 50] = 3'd6;
      wait_done(3, 1);
      do_scan(50, 50, 1, 1, 3'd6);

      // Random pixels and windows inside the defined area
      for (int i = 0; i < 40; i++)
         plot_px(int'($urandom_range(0, 40)), int'($urandom_range(0, 30)),
                 3'($urandom_range(1, 7)));
      for (int i = 0; i < 4; i++)
         do_scan(int'($urandom_range(0, 34)), int'($urandom_range(0, 24)),
                 int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                 3'($urandom_range(1, 7)));

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
